// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART word transmit path.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
  localparam int unsigned DATA_BITS            = 8;
  localparam logic        START_BIT            = 1'b0;
  localparam logic        STOP_BIT             = 1'b1;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SEND,
    W_DONE
  } word_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_e;

endpackage

// File: rtl/uart_byte_serializer.sv
// Emits one 8N1 frame per load; ready in the last stop-bit cycle lets frames chain with no gap.
module uart_byte_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data,
  output logic                 TxD,
  output logic                 ready,
  output logic                 byte_done
);

  localparam int unsigned     CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

  ser_state_e           state_q, state_d;
  logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 txd_q, txd_d;
  logic                 bit_end;

  assign bit_end   = (baud_cnt_q == BAUD_LAST);
  assign byte_done = (state_q == S_STOP) && bit_end;
  assign ready     = (state_q == S_IDLE) || byte_done;
  assign TxD       = txd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      sh_q       <= '0;
      txd_q      <= STOP_BIT;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      sh_q       <= sh_d;
      txd_q      <= txd_d;
    end
  end

  // Line level is derived from the next state so TxD changes on the same edge as the state.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    sh_d       = sh_q;
    txd_d      = STOP_BIT;

    if (state_q != S_IDLE) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d    = S_START;
          sh_d       = data;
          baud_cnt_d = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == BIT_LAST) begin
            state_d   = S_STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            sh_d      = sh_q >> 1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (load) begin
            state_d = S_START;
            sh_d    = data;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_START: txd_d = START_BIT;
      S_DATA:  txd_d = sh_d[0];
      default: txd_d = STOP_BIT;
    endcase
  end

endmodule

// File: rtl/uart_word_transmitter.sv
// Sends a 32-bit word as four chained 8N1 frames, byte 0 first, with a one-cycle done pulse.
module uart_word_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned BYTES_PER_WORD = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_BITS*BYTES_PER_WORD-1:0] TxD_word_data,
  input  logic                              TxD_word_start,
  output logic                              TxD,
  output logic                              TxD_busy,
  output logic                              TxD_word_done
);

  localparam int unsigned WORD_W    = DATA_BITS * BYTES_PER_WORD;
  localparam logic [1:0]  BYTE_LAST = 2'(BYTES_PER_WORD - 1);

  word_state_e           state_q, state_d;
  logic [WORD_W-1:0]     shreg_q, shreg_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ser_load;
  logic [DATA_BITS-1:0]  ser_data;
  logic                  ser_ready;
  logic                  ser_byte_done;
  logic                  accept;

  assign accept        = TxD_word_start && !busy_q && ser_ready;
  assign TxD_busy      = busy_q;
  assign TxD_word_done = done_q;

  uart_byte_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .data      (ser_data),
    .TxD       (TxD),
    .ready     (ser_ready),
    .byte_done (ser_byte_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= W_IDLE;
      shreg_q    <= '0;
      byte_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      byte_idx_q <= byte_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Byte 0 is fed straight from the input on accept; later bytes come from the shifted word.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_idx_d = byte_idx_q;
    ser_load   = 1'b0;
    ser_data   = shreg_q[2*DATA_BITS-1:DATA_BITS];

    unique case (state_q)
      W_IDLE, W_DONE: begin
        if (accept) begin
          state_d    = W_SEND;
          shreg_d    = TxD_word_data;
          byte_idx_d = '0;
          ser_load   = 1'b1;
          ser_data   = TxD_word_data[DATA_BITS-1:0];
        end else begin
          state_d = W_IDLE;
        end
      end
      W_SEND: begin
        if (ser_byte_done) begin
          if (byte_idx_q == BYTE_LAST) begin
            state_d    = W_DONE;
            byte_idx_d = '0;
          end else begin
            ser_load   = 1'b1;
            shreg_d    = shreg_q >> DATA_BITS;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      default: state_d = W_IDLE;
    endcase

    busy_d = (state_d == W_SEND);
    done_d = (state_d == W_DONE);
  end

endmodule

// File: tb/tb_uart_word_transmitter.sv
// Bench for uart_word_transmitter: bit-centre line monitor against a byte scoreboard plus timing checks.
module tb_uart_word_transmitter;

  localparam int CPB   = 4;
  localparam int HALF  = CPB / 2;
  localparam int WORDC = 40 * CPB;
  localparam int BOUND = 2000;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic        txd;
  logic        busy;
  logic        done;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  int       mon_cnt  = 0;
  int       mon_k    = 0;
  bit       in_frame = 1'b0;
  logic     prev_txd = 1'b1;
  logic [7:0] mon_byte = 8'h0;
  logic [7:0] exp_b;

  uart_word_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk            (clk),
    .rst            (rst),
    .TxD_word_data  (wdata),
    .TxD_word_start (start),
    .TxD            (txd),
    .TxD_busy       (busy),
    .TxD_word_done  (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  // Independent line decoder: find the start edge, then sample each bit at its centre.
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (prev_txd === 1'b1 && txd === 1'b0) begin
        in_frame = 1'b1;
        mon_cnt  = 0;
      end
    end else begin
      mon_cnt++;
    end
    if (in_frame && !rst) begin
      if (mon_cnt == HALF) begin
        checks++;
        if (txd !== 1'b0) begin
          errors++;
          $display("FAIL start_bit got %b expected 0 at %0t", txd, $time);
        end
      end else if (mon_cnt > HALF && ((mon_cnt - HALF) % CPB) == 0) begin
        mon_k = (mon_cnt - HALF) / CPB;
        if (mon_k <= 8) begin
          mon_byte[3'(mon_k - 1)] = txd;
        end else begin
          checks++;
          if (txd !== 1'b1) begin
            errors++;
            $display("FAIL stop_bit got %b expected 1 at %0t", txd, $time);
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte got %02h expected none at %0t", mon_byte, $time);
          end else begin
            exp_b = exp_q.pop_front();
            if (mon_byte !== exp_b) begin
              errors++;
              $display("FAIL byte_value got %02h expected %02h at %0t", mon_byte, exp_b, $time);
            end
          end
          in_frame = 1'b0;
        end
      end
    end
    prev_txd = txd;
  end

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  // Leaves the caller at the sample point of the first cycle after acceptance.
  task automatic kick(input logic [31:0] w);
    @(negedge clk);
    start = 1'b1;
    wdata = w;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic measure(output int nb);
    nb = 0;
    while (busy === 1'b1 && nb < BOUND) begin
      nb++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({txd, busy, done} !== 3'b100) begin
        errors++;
        $display("FAIL reset_idle got txd/busy/done=%b expected 100 cycle %0d", {txd, busy, done}, i);
      end
    end
  endtask

  task automatic test_single();
    int nb;
    int d0;
    d0 = done_cnt;
    push_word(32'h44332211);
    kick(32'h44332211);
    checks++;
    if (txd !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_first_cycle got txd=%b busy=%b expected txd=0 busy=1", txd, busy);
    end
    measure(nb);
    checks++;
    if (nb != WORDC) begin
      errors++;
      $display("FAIL single_busy_len got %0d expected %0d", nb, WORDC);
    end
    checks++;
    if (done !== 1'b1 || txd !== 1'b1) begin
      errors++;
      $display("FAIL single_done got done=%b txd=%b expected done=1 txd=1", done, txd);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after got done=%b txd=%b busy=%b expected 0 1 0", done, txd, busy);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL single_done_count got %0d expected 1", done_cnt - d0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_bytes_left got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    int nb;
    int d0;
    d0 = done_cnt;
    push_word(32'hA5A5A5A5);
    kick(32'hA5A5A5A5);
    nb = 0;
    while (busy === 1'b1 && nb < BOUND) begin
      nb++;
      if (nb == 49) begin
        start = 1'b1;
        wdata = 32'hDEADBEEF;
      end else if (nb == 50) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (nb != WORDC) begin
      errors++;
      $display("FAIL ignore_busy_len got %0d expected %0d", nb, WORDC);
    end
    repeat (50) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      errors++;
      $display("FAIL ignore_idle got busy=%b txd=%b expected 0 1", busy, txd);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL ignore_done_count got %0d expected 1", done_cnt - d0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ignore_bytes_left got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int nb;
    int d0;
    push_word(32'h12345678);
    kick(32'h12345678);
    for (int i = 1; i < 95; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state got txd=%b busy=%b done=%b expected 1 0 0", txd, busy, done);
    end
    rst = 1'b0;
    checks++;
    if (exp_q.size() != 2) begin
      errors++;
      $display("FAIL midreset_bytes_sent got %0d left expected 2", exp_q.size());
    end
    exp_q.delete();
    d0 = done_cnt;
    repeat (100) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0 || txd !== 1'b1) begin
      errors++;
      $display("FAIL midreset_quiet got dones=%0d busy=%b txd=%b expected 0 0 1", done_cnt - d0, busy, txd);
    end
    push_word(32'h0F0F0F0F);
    kick(32'h0F0F0F0F);
    measure(nb);
    checks++;
    if (nb != WORDC || done !== 1'b1) begin
      errors++;
      $display("FAIL midreset_resend got len=%0d done=%b expected %0d 1", nb, done, WORDC);
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_bytes_left got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int nb;
    int gap;
    int d0;
    d0 = done_cnt;
    push_word(32'h00000000);
    push_word(32'hFFFFFFFF);
    @(negedge clk);
    start = 1'b1;
    wdata = 32'h00000000;
    @(negedge clk);
    wdata = 32'hFFFFFFFF;
    measure(nb);
    checks++;
    if (nb != WORDC || done !== 1'b1 || txd !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got len=%0d done=%b txd=%b expected %0d 1 1", nb, done, txd, WORDC);
    end
    gap = 0;
    while (busy === 1'b0 && gap < BOUND) begin
      gap++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (gap != 1 || txd !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap got gap=%0d txd=%b expected 1 0", gap, txd);
    end
    measure(nb);
    checks++;
    if (nb != WORDC || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got len=%0d done=%b expected %0d 1", nb, done, WORDC);
    end
    @(negedge clk);
    checks++;
    if (done_cnt - d0 != 2) begin
      errors++;
      $display("FAIL b2b_done_count got %0d expected 2", done_cnt - d0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_bytes_left got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_boundary();
    int nb;
    push_word(32'h80000001);
    kick(32'h80000001);
    measure(nb);
    checks++;
    if (nb != WORDC || done !== 1'b1) begin
      errors++;
      $display("FAIL boundary_len got len=%0d done=%b expected %0d 1", nb, done, WORDC);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL boundary_bytes_left got %0d expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_boundary();
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
